// File: rtl/mem_stage_pipe_if.sv
// MEM-stage bus: EX/MEM side inputs and MEM/WB side registered outputs.
// The stage itself uses the slave modport; upstream/testbench drive via master.
interface mem_stage_pipe_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_W  = 4,
    parameter int unsigned CTRL_W = 11
);
    // EX/MEM side
    logic              valid_M;
    logic              flush_M;
    logic              forward_RW_M;
    logic              isLd_M;
    logic              isSt_M;
    logic              ld_signed_M;
    logic [1:0]        size_M;
    logic [DATA_W-1:0] alu_result_M;
    logic [DATA_W-1:0] rd2_M;
    logic [31:0]       pc_M;
    logic [31:0]       instruction_M;
    logic [REG_W-1:0]  RD_M;
    logic [CTRL_W-1:0] ctrl_M;
    logic              stall_M;

    // MEM/WB side
    logic              valid_RW;
    logic              isLd_RW;
    logic              isSt_RW;
    logic              misalign_RW;
    logic [31:0]       pc_RW;
    logic [31:0]       instruction_RW;
    logic [DATA_W-1:0] alu_result_RW;
    logic [DATA_W-1:0] ldresult_RW;
    logic [REG_W-1:0]  RD_RW;
    logic [CTRL_W-1:0] ctrl_RW;
    logic [DATA_W-1:0] memory_data_out;

    modport master (
        output valid_M, flush_M, forward_RW_M, isLd_M, isSt_M, ld_signed_M, size_M,
               alu_result_M, rd2_M, pc_M, instruction_M, RD_M, ctrl_M,
        input  stall_M, valid_RW, isLd_RW, isSt_RW, misalign_RW, pc_RW, instruction_RW,
               alu_result_RW, ldresult_RW, RD_RW, ctrl_RW, memory_data_out
    );

    modport slave (
        input  valid_M, flush_M, forward_RW_M, isLd_M, isSt_M, ld_signed_M, size_M,
               alu_result_M, rd2_M, pc_M, instruction_M, RD_M, ctrl_M,
        output stall_M, valid_RW, isLd_RW, isSt_RW, misalign_RW, pc_RW, instruction_RW,
               alu_result_RW, ldresult_RW, RD_RW, ctrl_RW, memory_data_out
    );
endinterface

// File: rtl/mem_stage_pipe.sv
// SimpleRISC MEM stage: data memory with byte/half/word access, configurable
// latency (stalls upstream), misalignment flagging and MEM/WB registers.
// Optional: define MEM_STAGE_FWD_EN to take store data from ldresult_RW when
// forward_RW_M is set (WB->MEM load-store forwarding).
module mem_stage_pipe #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned MEM_LAT = 1,
    parameter int unsigned REG_W   = 4,
    parameter int unsigned CTRL_W  = 11
) (
    input logic           clk,
    input logic           rst,
    mem_stage_pipe_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(MEM_LAT - 1);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ACCESS = 1'b1;

    logic [31:0]       mem [DEPTH];
    logic [0:0]        state_q;
    logic [CW-1:0]     cnt_q;

    logic [AW-1:0]     idx;
    logic [1:0]        lane;
    logic              misalign, memop, acc, stall, fire, we;
    logic [31:0]       rd_word, st_data, wdata, ld_val;
    logic [3:0]        be;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;

    logic              valid_q, isld_q, isst_q, mis_q;
    logic [31:0]       pc_q, instr_q;
    logic [DATA_W-1:0] alu_q, ldres_q;
    logic [REG_W-1:0]  rd_q;
    logic [CTRL_W-1:0] ctrl_q;

    assign idx  = bus.alu_result_M[AW+1:2];
    assign lane = bus.alu_result_M[1:0];

    // Alignment check per access size; size 11 is always illegal
    always_comb begin
        misalign = 1'b0;
        case (bus.size_M)
            2'b00:   misalign = 1'b0;
            2'b01:   misalign = lane[0];
            2'b10:   misalign = |lane;
            default: misalign = 1'b1;
        endcase
    end

    assign memop = bus.valid_M & (bus.isLd_M | bus.isSt_M);
    assign acc   = memop & ~misalign;
    // In IDLE cnt is 0, so the first cycle stalls only when MEM_LAT > 1
    assign stall = acc & ~bus.flush_M &
                   ((state_q == IDLE) ? (LAST_CNT != '0) : (cnt_q != LAST_CNT));
    assign fire  = bus.valid_M & ~bus.flush_M & ~stall;
    assign we    = fire & bus.isSt_M & ~misalign & ~rst;

    assign bus.stall_M = stall;

`ifdef MEM_STAGE_FWD_EN
    assign st_data = bus.forward_RW_M ? ldres_q : bus.rd2_M;
`else
    logic unused_fwd;
    assign unused_fwd = bus.forward_RW_M;
    assign st_data    = bus.rd2_M;
`endif

    assign rd_word             = mem[idx];
    assign bus.memory_data_out = rd_word;

    // Byte enables and lane-replicated write data
    always_comb begin
        be    = 4'b1111;
        wdata = st_data;
        case (bus.size_M)
            2'b00: begin
                be    = 4'b0001 << lane;
                wdata = {4{st_data[7:0]}};
            end
            2'b01: begin
                be    = lane[1] ? 4'b1100 : 4'b0011;
                wdata = {2{st_data[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wdata = st_data;
            end
        endcase
    end

    // Load lane extraction with optional sign extension
    assign byte_sel = rd_word[{lane, 3'b000} +: 8];
    assign half_sel = lane[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        ld_val = rd_word;
        case (bus.size_M)
            2'b00:   ld_val = bus.ld_signed_M ? {{24{byte_sel[7]}}, byte_sel} : {24'b0, byte_sel};
            2'b01:   ld_val = bus.ld_signed_M ? {{16{half_sel[15]}}, half_sel} : {16'b0, half_sel};
            default: ld_val = rd_word;
        endcase
    end

    // Data memory write port (contents survive reset)
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we && be[i]) begin
                mem[idx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    // Latency FSM: count stalled cycles of an aligned access, abort on flush
    always_ff @(posedge clk) begin
        if (rst || bus.flush_M) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else if (stall) begin
            state_q <= ACCESS;
            cnt_q   <= cnt_q + CW'(1);
        end else begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end
    end

    // MEM/WB pipeline registers; stalled or flushed cycles become bubbles
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            isld_q  <= 1'b0;
            isst_q  <= 1'b0;
            mis_q   <= 1'b0;
            pc_q    <= '0;
            instr_q <= '0;
            alu_q   <= '0;
            ldres_q <= '0;
            rd_q    <= '0;
            ctrl_q  <= '0;
        end else begin
            valid_q <= fire;
            if (fire) begin
                isld_q  <= bus.isLd_M;
                isst_q  <= bus.isSt_M;
                mis_q   <= memop & misalign;
                pc_q    <= bus.pc_M;
                instr_q <= bus.instruction_M;
                alu_q   <= bus.alu_result_M;
                ldres_q <= (bus.isLd_M && !misalign) ? ld_val : '0;
                rd_q    <= bus.RD_M;
                ctrl_q  <= bus.ctrl_M;
            end
        end
    end

    assign bus.valid_RW       = valid_q;
    assign bus.isLd_RW        = isld_q;
    assign bus.isSt_RW        = isst_q;
    assign bus.misalign_RW    = mis_q;
    assign bus.pc_RW          = pc_q;
    assign bus.instruction_RW = instr_q;
    assign bus.alu_result_RW  = alu_q;
    assign bus.ldresult_RW    = ldres_q;
    assign bus.RD_RW          = rd_q;
    assign bus.ctrl_RW        = ctrl_q;
endmodule
